// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes instruction memory.
// Latency: wen in the cycle after a word's 4th byte handshake; done one cycle after the final wen or last byte.
// Backpressure: rxready only in LEN0/LEN1/DATA/CHK; one byte per cycle accepted there. Macro LOADER_CHECKSUM_EN adds CHK.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rxvalid,
    input  logic [7:0]            rxdata,
    output logic                  rxready,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  cpuhold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHK  = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // State entered once the last data byte (or a zero count) has been taken.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    localparam logic [31:0]           L_MAX_WORDS = 32'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] L_BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_remain;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cpuhold;
    logic                  r_done;
    logic                  r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic [15:0] w_len;
    logic        w_len_big;
    logic        w_restart;
    logic        w_done_hold;

    assign w_len     = {rxdata, r_len_lo};
    assign w_len_big = {16'd0, w_len} > L_MAX_WORDS;
    assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    // done is held only while staying in DONE, so a restart drops it on the same edge.
    assign w_done_hold = (r_state == S_DONE) && (w_next == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and rxready; in accepting states rxvalid alone means a handshake.
    always_comb begin
        w_next  = r_state;
        rxready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN0;
            end
            S_LEN0: begin
                rxready = 1'b1;
                if (rxvalid) w_next = S_LEN1;
            end
            S_LEN1: begin
                rxready = 1'b1;
                if (rxvalid) begin
                    if (w_len == 16'd0)  w_next = S_FIN;
                    else if (w_len_big)  w_next = S_ERR;
                    else                 w_next = S_DATA;
                end
            end
            S_DATA: begin
                rxready = 1'b1;
                if (rxvalid && r_byte_idx == 2'd3 && r_remain == 16'd1) w_next = S_FIN;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                rxready = 1'b1;
                if (rxvalid) w_next = (rxdata == r_csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) w_next = S_LEN0;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write strobe and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_lo    <= 8'd0;
            r_remain    <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_next_addr <= L_BASE;
            r_wen       <= 1'b0;
            r_waddr     <= L_BASE;
            r_wdata     <= '0;
            r_cpuhold   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_wen     <= 1'b0;
            r_err     <= (w_next == S_ERR);
            r_done    <= w_done_hold;
            r_cpuhold <= ~w_done_hold;
            if (w_restart) begin
                r_byte_idx  <= 2'd0;
                r_next_addr <= L_BASE;
`ifdef LOADER_CHECKSUM_EN
                r_csum      <= 8'd0;
`endif
            end
            if (r_state == S_LEN0 && rxvalid) r_len_lo <= rxdata;
            if (r_state == S_LEN1 && rxvalid) r_remain <= w_len;
            if (r_state == S_DATA && rxvalid) begin
                r_wdata[{r_byte_idx, 3'b000} +: 8] <= rxdata;
                r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                r_csum <= r_csum + rxdata;
`endif
                if (r_byte_idx == 2'd3) begin
                    r_wen       <= 1'b1;
                    r_waddr     <= r_next_addr;
                    r_next_addr <= r_next_addr + ADDR_WIDTH'(4);
                    r_remain    <= r_remain - 16'd1;
                end
            end
        end
    end

    assign wen     = r_wen;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign cpuhold = r_cpuhold;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte streams against a stream-level reference model of imem_loader.
// Checks reset values, written words/addresses, done/err/cpuhold outcome and done/wen timing.
// Gaps, toggling rxvalid and stray start pulses exercise the handshake.
module tb_imem_loader;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXW = 1024;
    localparam int BASE = 0;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rxvalid = 1'b0;
    logic [7:0]    rxdata = 8'd0;
    logic          rxready;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          cpuhold;
    logic          done;
    logic          err;

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .rxvalid(rxvalid), .rxdata(rxdata),
        .rxready(rxready), .wen(wen), .waddr(waddr), .wdata(wdata),
        .cpuhold(cpuhold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Edge bookkeeping and write capture.
    int            edge_n = 0;
    int            hs_edge = 0;
    int            wen_edge = -100;
    int            done_edge = -1;
    logic          prev_done = 1'b0;
    logic [AW+DW-1:0] got[$];
    logic [7:0]    stim[$];

    always @(posedge clk) begin
        edge_n++;
        if (rxvalid && rxready) hs_edge = edge_n;
    end

    always @(negedge clk) begin
        if (wen) begin
            check_eq("wen_spacing_ge4", 32'(edge_n - wen_edge >= 4), 32'd1);
            check_eq("wen_not_with_done", done, 0);
            got.push_back({waddr, wdata});
            wen_edge = edge_n;
        end
        if (done && !prev_done) done_edge = edge_n;
        prev_done = done;
    end

    task automatic send_byte(input logic [7:0] b, input bit glitch_start);
        int n = 0;
        rxdata = b;
        rxvalid = 1'b1;
        start = glitch_start;
        while (!rxready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rxready_wait", rxready, 1);
        @(negedge clk);
        rxvalid = 1'b0;
        start = 1'b0;
    endtask

    task automatic make_image(input int cnt, input bit bad_csum);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        stim.delete();
        stim.push_back(cnt[7:0]);
        stim.push_back(cnt[15:8]);
        if (cnt <= MAXW) begin
            for (int i = 0; i < 4 * cnt; i++) begin
                b = 8'($urandom_range(0, 255));
                stim.push_back(b);
                sum = sum + b;
            end
            if (CSUM_EN) stim.push_back(bad_csum ? sum + 8'd1 : sum);
        end
    endtask

    // Start a load, stream stim, then compare against the stream-level model.
    task automatic run_load(input int gap_mode, input bit glitch);
        logic [AW+DW-1:0] exp_q[$];
        logic [7:0]       sum;
        logic [DW-1:0]    word;
        int               cnt, last, n, g;
        bit               len_ok, exp_ok;
        sum = 8'd0;
        cnt = int'({stim[1], stim[0]});
        len_ok = cnt <= MAXW;
        if (len_ok) begin
            for (int w = 0; w < cnt; w++) begin
                word = {stim[4*w+5], stim[4*w+4], stim[4*w+3], stim[4*w+2]};
                exp_q.push_back({AW'(BASE + 4 * w), word});
                for (int k = 2; k < 6; k++) sum = sum + stim[4*w+k];
            end
        end
        exp_ok = len_ok;
        if (CSUM_EN && len_ok) exp_ok = (stim[2 + 4*cnt] == sum);

        got.delete();
        done_edge = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_done_low", done, 0);
        check_eq("start_err_low", err, 0);
        check_eq("start_cpuhold_high", cpuhold, 1);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], glitch && ($urandom_range(0, 5) == 0));
            if (i != stim.size() - 1) begin
                g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
                for (int k = 0; k < g; k++) begin
                    check_eq("rxready_in_gap", rxready, 1);
                    @(negedge clk);
                end
            end
        end
        last = hs_edge;
        n = 0;
        while (!(done || err) && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        check_eq("done", done, 32'(exp_ok));
        check_eq("err", err, 32'(!exp_ok));
        check_eq("cpuhold", cpuhold, 32'(!exp_ok));
        check_eq("rxready_end", rxready, 0);
        check_eq("n_writes", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq("waddr", 32'(got[i][AW+DW-1:DW]), 32'(exp_q[i][AW+DW-1:DW]));
            check_eq("wdata", got[i][DW-1:0], exp_q[i][DW-1:0]);
        end
        if (exp_ok) check_eq("done_edge", done_edge, last + 1);
        if (exp_ok && cnt > 0 && !CSUM_EN) check_eq("final_wen_edge", wen_edge, last);
    endtask

    task automatic check_plan_words();
        check_eq("plan_waddr0", 32'(got[0][AW+DW-1:DW]), 32'h0000);
        check_eq("plan_wdata0", got[0][DW-1:0], 32'h00A00513);
        check_eq("plan_waddr1", 32'(got[1][AW+DW-1:DW]), 32'h0004);
        check_eq("plan_wdata1", got[1][DW-1:0], 32'h00100593);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, cnt;
        logic [DW-1:0] w0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_rxready", rxready, 0);
        check_eq("rst_wen", wen, 0);
        check_eq("rst_waddr", 32'(waddr), 32'(BASE));
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_cpuhold", cpuhold, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reference image, back-to-back then with rxvalid toggling.
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        if (CSUM_EN) stim.push_back(8'h60);
        run_load(0, 1'b0);
        check_plan_words();
        run_load(1, 1'b0);
        check_plan_words();

        // Count 0x0401 exceeds MAX_WORDS, then a valid image recovers.
        make_image(MAXW + 1, 1'b0);
        run_load(0, 1'b0);
        make_image(2, 1'b0);
        run_load(2, 1'b0);

        // Reset after six data bytes.
        make_image(2, 1'b0);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(stim[i], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_rxready", rxready, 0);
        check_eq("midrst_wen", wen, 0);
        check_eq("midrst_waddr", 32'(waddr), 32'(BASE));
        check_eq("midrst_wdata", wdata, 0);
        check_eq("midrst_cpuhold", cpuhold, 1);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_err", err, 0);
        w0 = {stim[5], stim[4], stim[3], stim[2]};
        check_eq("midrst_n_writes", got.size(), 1);
        check_eq("midrst_word0", got[0][DW-1:0], w0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        make_image(3, 1'b0);
        run_load(0, 1'b0);

        // Zero-length image.
        make_image(0, 1'b0);
        run_load(0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_load(0, 1'b0);
        check_eq("csum_good_done", done, 1);
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_load(0, 1'b0);
        check_eq("csum_bad_err", err, 1);
        check_eq("csum_bad_cpuhold", cpuhold, 1);
`endif

        // Largest accepted image.
        make_image(MAXW, 1'b0);
        run_load(0, 1'b0);

        // Randomized images.
        for (int r = 0; r < 12; r++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      cnt = int'($urandom_range(0, 5));
            else if (sel < 9) cnt = int'($urandom_range(MAXW + 1, 65535));
            else              cnt = 0;
            make_image(cnt, $urandom_range(0, 3) == 0);
            run_load(int'($urandom_range(0, 2)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
